// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline types and forwarding constants for the hazard/forwarding unit.
// Entry widths are fixed by DEF_REG_W; the top-level REG_W must match it.
package pipe_pkg;

    localparam int DEF_REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic                 valid;
        logic [DEF_REG_W-1:0] dst;
        logic                 regwrite;
        logic                 memread;
    } stage_ent_t;

    // The EX entry also carries its sources so forwarding can be resolved there.
    typedef struct packed {
        stage_ent_t           ent;
        logic [DEF_REG_W-1:0] rs;
        logic [DEF_REG_W-1:0] rt;
        logic                 uses_rs;
        logic                 uses_rt;
    } ex_ent_t;

    function automatic logic fwd_hit(input stage_ent_t e, input logic uses,
                                     input logic [DEF_REG_W-1:0] src);
        return e.valid && e.regwrite && (e.dst != '0) && uses && (e.dst == src);
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / EX-stage forwarding bus between the pipeline and the hazard unit.
interface fwd_hazard_unit_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 32
);
    logic             id_valid;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic [REG_W-1:0] id_dst;
    logic             id_regwrite;
    logic             id_memread;
    logic             flush;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic             stall;
    logic             bubble;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_regwrite, id_memread, flush,
        input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               id_dst, id_regwrite, id_memread, flush,
        output fwd_a_sel, fwd_b_sel, stall, bubble, stall_count
    );
endinterface

// File: rtl/fwd_hazard_unit_stage_reg.sv
// One shadow pipeline-stage entry: synchronous active-low clear, bubble loads an empty entry.
module hazard_stage_reg
    import pipe_pkg::*;
#(
    parameter type ent_t = stage_ent_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_bubble,
    input  ent_t i_d,
    output ent_t o_q
);

    ent_t r_q;

    // NOTE: sequential state uses non-blocking assignments so all three entries shift together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_bubble) begin
            r_q <= '0;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow EX/MEM/WB destination tracking, EX operand forwarding selects,
// load-use stall/bubble generation and a saturating stall counter.
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_W = DEF_REG_W,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);

    ex_ent_t          w_id_ent;
    ex_ent_t          w_ex_ent;
    stage_ent_t       w_mem_ent;
    stage_ent_t       w_wb_ent;
    logic             w_hz;
    logic             w_stall;
    logic             w_bubble;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;
    logic [CNT_W-1:0] r_stall_count;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no latch is inferred.
        w_id_ent              = '0;
        w_id_ent.ent.valid    = bus.id_valid;
        w_id_ent.ent.dst      = bus.id_dst;
        w_id_ent.ent.regwrite = bus.id_regwrite;
        w_id_ent.ent.memread  = bus.id_memread;
        w_id_ent.rs           = bus.id_rs;
        w_id_ent.rt           = bus.id_rt;
        w_id_ent.uses_rs      = bus.id_uses_rs;
        w_id_ent.uses_rt      = bus.id_uses_rt;
    end

    hazard_stage_reg #(.ent_t(ex_ent_t)) u_ex (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (w_bubble),
        .i_d      (w_id_ent),
        .o_q      (w_ex_ent)
    );

    hazard_stage_reg #(.ent_t(stage_ent_t)) u_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (1'b0),
        .i_d      (w_ex_ent.ent),
        .o_q      (w_mem_ent)
    );

    hazard_stage_reg #(.ent_t(stage_ent_t)) u_wb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (1'b0),
        .i_d      (w_mem_ent),
        .o_q      (w_wb_ent)
    );

    // A load in EX whose result the ID instruction needs cannot be forwarded in time.
    always_comb begin
        w_hz = w_id_ent.ent.valid
            && w_ex_ent.ent.valid && w_ex_ent.ent.memread && w_ex_ent.ent.regwrite
            && (w_ex_ent.ent.dst != '0)
            && ((w_id_ent.uses_rs && (w_id_ent.rs == w_ex_ent.ent.dst))
             || (w_id_ent.uses_rt && (w_id_ent.rt == w_ex_ent.ent.dst)));
        w_stall  = w_hz && !bus.flush;
        w_bubble = w_hz || bus.flush;
    end

    // MEM holds the younger result, so it wins over WB.
    always_comb begin
        w_fwd_a = FWD_RF;
        if (fwd_hit(w_mem_ent, w_ex_ent.uses_rs, w_ex_ent.rs)) begin
            w_fwd_a = FWD_MEM;
        end else if (fwd_hit(w_wb_ent, w_ex_ent.uses_rs, w_ex_ent.rs)) begin
            w_fwd_a = FWD_WB;
        end

        w_fwd_b = FWD_RF;
        if (fwd_hit(w_mem_ent, w_ex_ent.uses_rt, w_ex_ent.rt)) begin
            w_fwd_b = FWD_MEM;
        end else if (fwd_hit(w_wb_ent, w_ex_ent.uses_rt, w_ex_ent.rt)) begin
            w_fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign bus.fwd_a_sel   = w_fwd_a;
    assign bus.fwd_b_sel   = w_fwd_b;
    assign bus.stall       = w_stall;
    assign bus.bubble      = w_bubble;
    assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scenario bench for fwd_hazard_unit: hand-derived expectations queued per cycle and
// compared half a cycle later; a narrow counter makes saturation reachable.
module tb_fwd_hazard_unit;
    import pipe_pkg::*;

    localparam int REG_W = 5;
    localparam int CNT_W = 2;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic             uses_rs;
        logic             uses_rt;
        logic [REG_W-1:0] dst;
        logic             regwrite;
        logic             memread;
    } instr_t;

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       stall;
        logic       bubble;
    } exp_t;

    typedef struct {
        instr_t ins;
        logic   fl;
        logic   rst;
        exp_t   e;
    } row_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    row_t             stim_q[$];
    exp_t             exp_q[$];
    int               n_total = 0;
    int               n_pass  = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic             last_rst;
    logic             last_stall;

    function automatic instr_t nop();
        return '0;
    endfunction

    function automatic instr_t alu(input int d, input int s, input int t);
        instr_t i = '0;
        i.valid = 1'b1; i.rs = REG_W'(s); i.rt = REG_W'(t);
        i.uses_rs = 1'b1; i.uses_rt = 1'b1; i.dst = REG_W'(d); i.regwrite = 1'b1;
        return i;
    endfunction

    function automatic instr_t lw(input int t, input int base);
        instr_t i = '0;
        i.valid = 1'b1; i.rs = REG_W'(base); i.rt = REG_W'(t);
        i.uses_rs = 1'b1; i.dst = REG_W'(t); i.regwrite = 1'b1; i.memread = 1'b1;
        return i;
    endfunction

    function automatic exp_t ex(input logic [1:0] a, input logic [1:0] b,
                                input logic s, input logic bb);
        exp_t e;
        e.a = a; e.b = b; e.stall = s; e.bubble = bb;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.a = bus.fwd_a_sel; o.b = bus.fwd_b_sel; o.stall = bus.stall; o.bubble = bus.bubble;
        return o;
    endfunction

    task automatic add_row(input instr_t ins, input logic fl, input logic rst, input exp_t e);
        row_t r;
        r.ins = ins; r.fl = fl; r.rst = rst; r.e = e;
        stim_q.push_back(r);
    endtask

    task automatic drive_ins(input instr_t ins, input logic fl);
        bus.id_valid    = ins.valid;
        bus.id_rs       = ins.rs;
        bus.id_rt       = ins.rt;
        bus.id_uses_rs  = ins.uses_rs;
        bus.id_uses_rt  = ins.uses_rt;
        bus.id_dst      = ins.dst;
        bus.id_regwrite = ins.regwrite;
        bus.id_memread  = ins.memread;
        bus.flush       = fl;
    endtask

    task automatic drive_next();
        row_t r = stim_q.pop_front();
        drive_ins(r.ins, r.fl);
        rst_n      = r.rst;
        last_rst   = r.rst;
        last_stall = r.e.stall;
        exp_q.push_back(r.e);
    endtask

    // Advance one edge and update the expected counter from the expected stall.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!last_rst) exp_cnt = '0;
        else if (last_stall && (exp_cnt != '1)) exp_cnt = exp_cnt + CNT_W'(1);
    endtask

    task automatic reset_dut();
        stim_q.delete();
        exp_q.delete();
        drive_ins(nop(), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_reset();
        exp_t got, e;
        int   cyc = 0;
        reset_dut();
        add_row(alu(3, 1, 2), 1'b0, 1'b0, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 3, 3), 1'b1, 1'b0, ex(FWD_RF, FWD_RF, 1'b0, 1'b1));
        while (stim_q.size() != 0) begin
            drive_next(); @(negedge clk);
            e = exp_q.pop_front(); got = observed(); n_total += 2;
            if (got !== e) $display("FAIL reset c%0d: {a,b,stall,bubble} got %b want %b", cyc, got, e); else n_pass++;
            if (bus.stall_count !== exp_cnt) $display("FAIL reset_count c%0d: got %0d want %0d", cyc, bus.stall_count, exp_cnt); else n_pass++;
            tick(); cyc++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t got, e;
        int   cyc = 0;
        reset_dut();
        add_row(alu(3, 1, 2), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 3, 5), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_MEM, FWD_RF, 1'b0, 1'b0));
        while (stim_q.size() != 0) begin
            drive_next(); @(negedge clk);
            e = exp_q.pop_front(); got = observed(); n_total += 2;
            if (got !== e) $display("FAIL back_to_back c%0d: {a,b,stall,bubble} got %b want %b", cyc, got, e); else n_pass++;
            if (bus.stall_count !== exp_cnt) $display("FAIL back_to_back_count c%0d: got %0d want %0d", cyc, bus.stall_count, exp_cnt); else n_pass++;
            tick(); cyc++;
        end
    endtask

    task automatic test_one_gap_and_double();
        exp_t got, e;
        int   cyc = 0;
        reset_dut();
        add_row(alu(3, 1, 2), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(7, 8, 9), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 3, 5), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(3, 1, 2), 1'b0, 1'b1, ex(FWD_WB, FWD_RF, 1'b0, 1'b0));
        add_row(alu(3, 6, 7), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_MEM, FWD_MEM, 1'b0, 1'b0));
        while (stim_q.size() != 0) begin
            drive_next(); @(negedge clk);
            e = exp_q.pop_front(); got = observed(); n_total += 2;
            if (got !== e) $display("FAIL gap_double c%0d: {a,b,stall,bubble} got %b want %b", cyc, got, e); else n_pass++;
            if (bus.stall_count !== exp_cnt) $display("FAIL gap_double_count c%0d: got %0d want %0d", cyc, bus.stall_count, exp_cnt); else n_pass++;
            tick(); cyc++;
        end
    endtask

    task automatic test_load_use_and_r0();
        exp_t got, e;
        int   cyc = 0;
        reset_dut();
        add_row(lw(3, 1),     1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b1, 1'b1));
        add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_WB, FWD_WB, 1'b0, 1'b0));
        add_row(lw(0, 1),     1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 0, 0), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        while (stim_q.size() != 0) begin
            drive_next(); @(negedge clk);
            e = exp_q.pop_front(); got = observed(); n_total += 2;
            if (got !== e) $display("FAIL load_use c%0d: {a,b,stall,bubble} got %b want %b", cyc, got, e); else n_pass++;
            if (bus.stall_count !== exp_cnt) $display("FAIL load_use_count c%0d: got %0d want %0d", cyc, bus.stall_count, exp_cnt); else n_pass++;
            tick(); cyc++;
        end
    endtask

    task automatic test_flush_then_reset();
        exp_t got, e;
        int   cyc = 0;
        reset_dut();
        add_row(lw(3, 1),     1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 3, 3), 1'b1, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b1));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(5, 1, 2), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(6, 5, 5), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(7, 6, 6), 1'b0, 1'b1, ex(FWD_MEM, FWD_MEM, 1'b0, 1'b0));
        add_row(alu(8, 7, 7), 1'b0, 1'b0, ex(FWD_MEM, FWD_MEM, 1'b0, 1'b0));
        add_row(alu(9, 7, 6), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        while (stim_q.size() != 0) begin
            drive_next(); @(negedge clk);
            e = exp_q.pop_front(); got = observed(); n_total += 2;
            if (got !== e) $display("FAIL flush_reset c%0d: {a,b,stall,bubble} got %b want %b", cyc, got, e); else n_pass++;
            if (bus.stall_count !== exp_cnt) $display("FAIL flush_reset_count c%0d: got %0d want %0d", cyc, bus.stall_count, exp_cnt); else n_pass++;
            tick(); cyc++;
        end
    endtask

    task automatic test_reset_mid_stall();
        exp_t got, e;
        int   cyc = 0;
        reset_dut();
        add_row(lw(3, 1),     1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b1, 1'b1));
        add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(lw(3, 1),     1'b0, 1'b1, ex(FWD_WB, FWD_WB, 1'b0, 1'b0));
        add_row(alu(4, 3, 3), 1'b0, 1'b0, ex(FWD_RF, FWD_RF, 1'b1, 1'b1));
        add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        add_row(nop(),        1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        while (stim_q.size() != 0) begin
            drive_next(); @(negedge clk);
            e = exp_q.pop_front(); got = observed(); n_total += 2;
            if (got !== e) $display("FAIL mid_stall_reset c%0d: {a,b,stall,bubble} got %b want %b", cyc, got, e); else n_pass++;
            if (bus.stall_count !== exp_cnt) $display("FAIL mid_stall_reset_count c%0d: got %0d want %0d", cyc, bus.stall_count, exp_cnt); else n_pass++;
            tick(); cyc++;
        end
    endtask

    task automatic test_saturation();
        exp_t got, e;
        int   cyc = 0;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            add_row(lw(3, 1), 1'b0, 1'b1,
                    (i == 0) ? ex(FWD_RF, FWD_RF, 1'b0, 1'b0) : ex(FWD_WB, FWD_WB, 1'b0, 1'b0));
            add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b1, 1'b1));
            add_row(alu(4, 3, 3), 1'b0, 1'b1, ex(FWD_RF, FWD_RF, 1'b0, 1'b0));
        end
        add_row(nop(), 1'b0, 1'b1, ex(FWD_WB, FWD_WB, 1'b0, 1'b0));
        while (stim_q.size() != 0) begin
            drive_next(); @(negedge clk);
            e = exp_q.pop_front(); got = observed(); n_total += 2;
            if (got !== e) $display("FAIL saturation c%0d: {a,b,stall,bubble} got %b want %b", cyc, got, e); else n_pass++;
            if (bus.stall_count !== exp_cnt) $display("FAIL saturation_count c%0d: got %0d want %0d", cyc, bus.stall_count, exp_cnt); else n_pass++;
            tick(); cyc++;
        end
        n_total++;
        if (bus.stall_count !== 2'b11) $display("FAIL saturation_final: got %0d want 3", bus.stall_count);
        else n_pass++;
    endtask

    // Valid code never leaves a matching load in MEM for the EX instruction.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut.w_ex_ent.ent.valid === 1'b1 && dut.w_mem_ent.memread === 1'b1
            && dut.w_mem_ent.valid === 1'b1 && dut.w_mem_ent.regwrite === 1'b1 && dut.w_mem_ent.dst != '0
            && ((dut.w_ex_ent.uses_rs && dut.w_ex_ent.rs == dut.w_mem_ent.dst)
             || (dut.w_ex_ent.uses_rt && dut.w_ex_ent.rt == dut.w_mem_ent.dst))) begin
            n_total++;
            $display("FAIL load_in_mem_forward: load dst %0d in MEM matched by EX", dut.w_mem_ent.dst);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive_ins(nop(), 1'b0);
        exp_cnt    = '0;
        last_rst   = 1'b0;
        last_stall = 1'b0;
        test_reset();
        test_back_to_back();
        test_one_gap_and_double();
        test_load_use_and_r0();
        test_flush_then_reset();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Tracks the destination registers of instructions in flight through the EX, MEM and WB stages and generates the 2-bit select codes for the EX-stage operand forwarding muxes (`MUX3`, codes 00/01/10). It also detects load-use hazards at decode and produces the stall and bubble controls. It sits between the ID/EX control path and the EX-stage operand muxes, and keeps its own shadow copy of the pipeline's register-write state.

## Interface

- `REG_W`, default 5: register-specifier width.
- `CNT_W`, default 32: stall performance-counter width.

- `clk` input 1: pipeline clock.
- `rst_n` input 1: synchronous, active-low reset.
- `id_valid` input 1: the ID stage holds a real instruction.
- `id_rs`, `id_rt` input REG_W: source specifiers of the ID instruction.
- `id_uses_rs`, `id_uses_rt` input 1: the ID instruction actually reads rs / rt.
- `id_dst` input REG_W: destination specifier of the ID instruction, already resolved rd/rt/31.
- `id_regwrite` input 1: the ID instruction writes the register file.
- `id_memread` input 1: the ID instruction is a load.
- `flush` input 1: a taken branch or jump resolved in EX; kills the ID instruction.
- `fwd_a_sel`, `fwd_b_sel` output 2: EX operand A/B mux select. 00 = ID/EX register value, 01 = EX/MEM ALU result, 10 = MEM/WB writeback data.
- `stall` output 1: hold the PC and the IF/ID register.
- `bubble` output 1: load a NOP into ID/EX this cycle.
- `stall_count` output CNT_W: count of stall cycles, saturating.

## Operation

- Three internal stage entries: EX, MEM, WB. Each entry holds {valid, dst, regwrite, memread}. The EX entry additionally holds rs, rt, uses_rs and uses_rt.
- Entries advance every cycle, in this order: WB←MEM, MEM←EX, then EX←ID-entry. The EX entry takes the ID entry unless `bubble` is asserted, in which case EX becomes invalid. There is no global enable.
- Load-use hazard:
  - `hz` is asserted when all of the following hold: `id_valid`, the EX entry is valid with memread and regwrite, EX.dst ≠ 0, and either (`id_uses_rs` and `id_rs`==EX.dst) or (`id_uses_rt` and `id_rt`==EX.dst).
  - `stall = hz & ~flush`.
  - `bubble = hz | flush`.
- Forwarding for operand A (B is identical, using rt/uses_rt):
  - Select 01 if the MEM entry is valid, has regwrite, MEM.dst ≠ 0, EX.uses_rs, and MEM.dst==EX.rs.
  - Otherwise select 10 under the same conditions applied to the WB entry.
  - Otherwise select 00.
  - MEM has priority over WB.
- A load in MEM that matches is still selected as 01. The load-use stall guarantees this case never occurs for valid code, and the bench flags it as an assertion.
- Register 0 is never forwarded and never causes a stall.
- Same-cycle WB-write/ID-read is resolved by a write-first register file. It is out of scope here.
- `stall_count` increments by 1 on each cycle with `stall`=1, and saturates at all-ones.

## Timing

- Reset: on the first `clk` edge with `rst_n`=0, all entries are cleared to invalid and `stall_count`=0.
- Consequences of reset: `fwd_a_sel`/`fwd_b_sel`=00, and `stall`=0 / `bubble`=0 unless `flush` is asserted.
- Reset asserted mid-stall clears state on that edge. The next cycle shows no hazard from pre-reset instructions.
- Forward selects are combinational from the registered entries. They are valid in the same cycle the instruction occupies EX, with zero added latency.
- `stall`/`bubble` are combinational from the ID inputs and the EX entry. They are consumed at the same edge that advances the entries.
- A load-use stall lasts exactly one cycle. The next cycle:
  - The load is in MEM and the consumer is still in ID.
  - The EX entry is a bubble, so `hz`=0.
  - The consumer enters EX one cycle later, with select 10 from WB.
- `flush` and `hz` in the same cycle: `flush` wins. Result is `stall`=0, `bubble`=1.

## Structure

- Shared package `pipe_pkg` holds:
  - Typedef `stage_ent_t` {valid, dst, regwrite, memread}.
  - Constants `FWD_RF`=2'b00, `FWD_MEM`=2'b01, `FWD_WB`=2'b10.
- One sub-module, `hazard_stage_reg`: a single entry register with synchronous active-low clear and a bubble input. It is instantiated three times.
- Compare/priority logic and the counter live in the top module.

## Test plan

- **Back-to-back ALU:** `add $3,$1,$2` then `sub $4,$3,$5` → second instruction in EX shows `fwd_a_sel`=01, `fwd_b_sel`=00, and `stall`=0 throughout.
- **One-gap ALU:** the same pair with an unrelated instruction between them → consumer in EX shows `fwd_a_sel`=10.
- **Double hazard:** `add $3`, `add $3`, `sub $4,$3,$3` → both selects =01 (MEM beats WB).
- **Load-use:** `lw $3,0($1)` then `add $4,$3,$3` → `stall`=`bubble`=1 for exactly one cycle, `stall_count` 0→1, then consumer in EX with both selects =10.
- **Register zero:** `lw $0` then `add $4,$0,$0` → no stall; selects 00.
- **Flush collides with load-use:**
  - `flush`=1 together with the load-use condition → `stall`=0, `bubble`=1, and `stall_count` unchanged.
  - Then reset asserted with three valid entries → all selects 00 on the next cycle.
